// File: rtl/rggen_register_access_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// rggen_register_access_sequencer_pkg : response status codes and FSM states
// Revision: 1.0
// ============================================================================
package rggen_register_access_sequencer_pkg;

   localparam logic [1:0] STATUS_OKAY        = 2'b00;
   localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;

   typedef enum logic [1:0] {
      STATE_IDLE     = 2'd0,
      STATE_ACCESS   = 2'd1,
      STATE_RESPONSE = 2'd2
   } state_e;

   // Number of byte-offset bits inside one bus word.
   function automatic int unsigned word_shift(input int unsigned bus_width);
      return $clog2(bus_width / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_address_decoder.sv
`default_nettype none
// ============================================================================
// rggen_address_decoder : byte address to one-hot register select plus miss
// Revision: 1.0
// ============================================================================
module rggen_address_decoder #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned BASE_ADDRESS  = 0,
   parameter int unsigned REGISTERS     = 4,
   parameter int unsigned WORD_SHIFT    = 2
) (
   input  logic [ADDRESS_WIDTH-1:0] address,
   output logic [REGISTERS-1:0]     hit,
   output logic                     miss
);

   localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDRESS);

   logic                     in_range;
   logic [ADDRESS_WIDTH-1:0] word_index;

   // Below-base addresses would wrap in the subtraction, so gate them out first.
   assign in_range   = address >= BASE;
   assign word_index = (address - BASE) >> WORD_SHIFT;

   always_comb begin
      hit = '0;
      for (int i = 0; i < int'(REGISTERS); i++) begin
         hit[i] = in_range && (word_index == ADDRESS_WIDTH'(i));
      end
   end

   assign miss = ~|hit;

endmodule
`default_nettype wire

// File: rtl/rggen_register_access_sequencer.sv
`default_nettype none
// ============================================================================
// rggen_register_access_sequencer : one host request -> one bit-field strobe
// Revision: 1.0
// ============================================================================
module rggen_register_access_sequencer
   import rggen_register_access_sequencer_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned BUS_WIDTH     = 32,
   parameter int unsigned REGISTERS     = 4,
   parameter int unsigned BASE_ADDRESS  = 0
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_req_valid,
   output logic                           o_req_ready,
   input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
   input  logic                           i_req_write,
   input  logic [BUS_WIDTH-1:0]           i_req_write_data,
   input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
   output logic                           o_resp_valid,
   input  logic                           i_resp_ready,
   output logic [1:0]                     o_resp_status,
   output logic [BUS_WIDTH-1:0]           o_resp_read_data,
   output logic [REGISTERS-1:0]           o_register_valid,
   output logic [BUS_WIDTH-1:0]           o_register_read_mask,
   output logic [BUS_WIDTH-1:0]           o_register_write_mask,
   output logic [BUS_WIDTH-1:0]           o_register_write_data,
   input  logic [REGISTERS*BUS_WIDTH-1:0] i_register_read_data
);

   localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;
   localparam int unsigned WORD_SHIFT   = word_shift(BUS_WIDTH);

   state_e                   state;
   state_e                   state_next;
   logic [ADDRESS_WIDTH-1:0] req_address;
   logic                     req_write;
   logic [BUS_WIDTH-1:0]     req_write_data;
   logic [STROBE_WIDTH-1:0]  req_strobe;
   logic [REGISTERS-1:0]     hit;
   logic                     miss;
   logic [BUS_WIDTH-1:0]     strobe_mask;
   logic [BUS_WIDTH-1:0]     selected_read_data;
   logic                     request_accept;
   logic                     access_active;

   assign request_accept = (state == STATE_IDLE) && i_req_valid;
   assign access_active  = (state == STATE_ACCESS);

   rggen_address_decoder #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .BASE_ADDRESS  (BASE_ADDRESS),
      .REGISTERS     (REGISTERS),
      .WORD_SHIFT    (WORD_SHIFT)
   ) u_address_decoder (
      .address (req_address),
      .hit     (hit),
      .miss    (miss)
   );

   for (genvar b = 0; b < int'(STROBE_WIDTH); b++) begin : g_strobe_mask
      assign strobe_mask[8*b +: 8] = {8{req_strobe[b]}};
   end

   // Misses leave hit all-zero, so the OR-mux returns zero for them.
   always_comb begin
      selected_read_data = '0;
      for (int i = 0; i < int'(REGISTERS); i++) begin
         if (hit[i]) begin
            selected_read_data = selected_read_data
                               | i_register_read_data[i*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= STATE_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Bit-field strobes decode from state only; reset therefore drops them at once.
   always_comb begin
      state_next            = state;
      o_req_ready           = 1'b0;
      o_resp_valid          = 1'b0;
      o_register_valid      = '0;
      o_register_read_mask  = '0;
      o_register_write_mask = '0;
      o_register_write_data = '0;
      case (state)
         STATE_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               state_next = STATE_ACCESS;
            end
         end
         STATE_ACCESS: begin
            state_next       = STATE_RESPONSE;
            o_register_valid = hit;
            if (!miss) begin
               if (req_write) begin
                  o_register_write_mask = strobe_mask;
                  o_register_write_data = req_write_data;
               end else begin
                  o_register_read_mask = '1;
               end
            end
         end
         STATE_RESPONSE: begin
            o_resp_valid = 1'b1;
            if (i_resp_ready) begin
               state_next = STATE_IDLE;
            end
         end
         default: begin
            state_next = STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_address    <= '0;
         req_write      <= 1'b0;
         req_write_data <= '0;
         req_strobe     <= '0;
      end else if (request_accept) begin
         req_address    <= i_req_address;
         req_write      <= i_req_write;
         req_write_data <= i_req_write_data;
         req_strobe     <= i_req_strobe;
      end
   end

   // Read data is captured in the strobe cycle, before any read side effect lands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_resp_status    <= STATUS_OKAY;
         o_resp_read_data <= '0;
      end else if (access_active) begin
         o_resp_status    <= miss ? STATUS_SLAVE_ERROR : STATUS_OKAY;
         o_resp_read_data <= req_write ? '0 : selected_read_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rggen_register_access_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rggen_register_access_sequencer : directed self-checking bench
// Revision: 1.0
// ============================================================================
module tb_rggen_register_access_sequencer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [7:0]   req_address;
   logic         req_write;
   logic [31:0]  req_write_data;
   logic [3:0]   req_strobe;
   logic         resp_valid;
   logic         resp_ready;
   logic [1:0]   resp_status;
   logic [31:0]  resp_read_data;
   logic [3:0]   register_valid;
   logic [31:0]  register_read_mask;
   logic [31:0]  register_write_mask;
   logic [31:0]  register_write_data;
   logic [127:0] register_read_data;

   int n_checks = 0;
   int n_errors = 0;
   int pulse_count = 0;

   localparam logic [31:0] REG0 = 32'h1111_0000;
   localparam logic [31:0] REG1 = 32'h2222_0001;
   localparam logic [31:0] REG2 = 32'h3333_0002;
   localparam logic [31:0] REG3 = 32'hDEAD_BEEF;

   assign register_read_data = {REG3, REG2, REG1, REG0};

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (|register_valid) pulse_count <= pulse_count + 1;
   end

   rggen_register_access_sequencer #(
      .ADDRESS_WIDTH (8),
      .BUS_WIDTH     (32),
      .REGISTERS     (4),
      .BASE_ADDRESS  (32'h10)
   ) dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_req_valid           (req_valid),
      .o_req_ready           (req_ready),
      .i_req_address         (req_address),
      .i_req_write           (req_write),
      .i_req_write_data      (req_write_data),
      .i_req_strobe          (req_strobe),
      .o_resp_valid          (resp_valid),
      .i_resp_ready          (resp_ready),
      .o_resp_status         (resp_status),
      .o_resp_read_data      (resp_read_data),
      .o_register_valid      (register_valid),
      .o_register_read_mask  (register_read_mask),
      .o_register_write_mask (register_write_mask),
      .o_register_write_data (register_write_data),
      .i_register_read_data  (register_read_data)
   );

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // One complete transaction; hold = extra RESPONSE cycles with resp_ready low.
   task automatic run_access(input string tag, input logic write, input logic [7:0] address,
                             input logic [31:0] data, input logic [3:0] strobe,
                             input logic [3:0] exp_valid, input logic [31:0] exp_wmask,
                             input logic [31:0] exp_rmask, input logic [31:0] exp_wdata,
                             input logic [1:0] exp_status, input logic [31:0] exp_rdata,
                             input int hold);
      int start_pulses;
      @(negedge clk);
      check({tag, ":idle_ready"}, 64'(req_ready), 64'd1);
      start_pulses   = pulse_count;
      req_valid      = 1'b1;
      req_write      = write;
      req_address    = address;
      req_write_data = data;
      req_strobe     = strobe;
      @(posedge clk);
      #1;
      req_valid      = 1'b0;
      req_write_data = 32'h0;
      req_strobe     = 4'h0;
      @(negedge clk);
      check({tag, ":valid"},      64'(register_valid),      64'(exp_valid));
      check({tag, ":wmask"},      64'(register_write_mask), 64'(exp_wmask));
      check({tag, ":rmask"},      64'(register_read_mask),  64'(exp_rmask));
      check({tag, ":wdata"},      64'(register_write_data), 64'(exp_wdata));
      check({tag, ":busy_ready"}, 64'(req_ready),           64'd0);
      check({tag, ":early_resp"}, 64'(resp_valid),          64'd0);
      for (int k = 0; k <= hold; k++) begin
         @(negedge clk);
         check({tag, ":resp_valid"}, 64'(resp_valid),     64'd1);
         check({tag, ":status"},     64'(resp_status),    64'(exp_status));
         check({tag, ":rdata"},      64'(resp_read_data), 64'(exp_rdata));
         check({tag, ":resp_ready"}, 64'(req_ready),      64'd0);
         check({tag, ":no_revalid"}, 64'(register_valid), 64'd0);
         if (k == hold) resp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check({tag, ":back_idle"},  64'(req_ready),  64'd1);
      check({tag, ":resp_done"},  64'(resp_valid), 64'd0);
      check({tag, ":pulses"},     64'(pulse_count - start_pulses),
            (exp_valid != 4'h0) ? 64'd1 : 64'd0);
   endtask

   initial begin
      logic [7:0]  b2b_addr [4];
      logic [31:0] b2b_data [4];
      b2b_addr = '{8'h10, 8'h14, 8'h18, 8'h1C};
      b2b_data = '{REG0, REG1, REG2, REG3};

      rst_n          = 1'b0;
      req_valid      = 1'b0;
      req_address    = 8'h0;
      req_write      = 1'b0;
      req_write_data = 32'h0;
      req_strobe     = 4'h0;
      resp_ready     = 1'b0;

      repeat (2) @(negedge clk);
      check("rst:req_ready",  64'(req_ready),           64'd1);
      check("rst:resp_valid", 64'(resp_valid),          64'd0);
      check("rst:status",     64'(resp_status),         64'd0);
      check("rst:rdata",      64'(resp_read_data),      64'd0);
      check("rst:valid",      64'(register_valid),      64'd0);
      check("rst:rmask",      64'(register_read_mask),  64'd0);
      check("rst:wmask",      64'(register_write_mask), 64'd0);
      check("rst:wdata",      64'(register_write_data), 64'd0);
      rst_n = 1'b1;

      run_access("wr14", 1'b1, 8'h14, 32'hA5A5_1234, 4'b0011, 4'b0010,
                 32'h0000_FFFF, 32'h0, 32'hA5A5_1234, 2'b00, 32'h0, 0);
      run_access("wr17", 1'b1, 8'h17, 32'h0BAD_F00D, 4'b1100, 4'b0010,
                 32'hFFFF_0000, 32'h0, 32'h0BAD_F00D, 2'b00, 32'h0, 0);
      run_access("rd1C", 1'b0, 8'h1C, 32'h0, 4'hF, 4'b1000,
                 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b00, REG3, 0);
      run_access("rd13", 1'b0, 8'h13, 32'h0, 4'h0, 4'b0001,
                 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b00, REG0, 0);
      run_access("rd20", 1'b0, 8'h20, 32'h0, 4'h0, 4'b0000,
                 32'h0, 32'h0, 32'h0, 2'b10, 32'h0, 0);
      run_access("rd0C", 1'b0, 8'h0C, 32'h0, 4'h0, 4'b0000,
                 32'h0, 32'h0, 32'h0, 2'b10, 32'h0, 0);
      run_access("wr24", 1'b1, 8'h24, 32'hFFFF_FFFF, 4'hF, 4'b0000,
                 32'h0, 32'h0, 32'h0, 2'b10, 32'h0, 0);
      run_access("rd10_hold", 1'b0, 8'h10, 32'h0, 4'h0, 4'b0001,
                 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b00, REG0, 10);

      // Back-to-back reads with req_valid and resp_ready held high.
      @(negedge clk);
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = b2b_addr[0];
      resp_ready  = 1'b1;
      for (int c = 0; c < 12; c++) begin
         check("b2b:req_ready",  64'(req_ready),  (c % 3 == 0) ? 64'd1 : 64'd0);
         check("b2b:resp_valid", 64'(resp_valid), (c % 3 == 2) ? 64'd1 : 64'd0);
         if (c % 3 == 2) check("b2b:rdata", 64'(resp_read_data), 64'(b2b_data[c / 3]));
         @(posedge clk);
         #1;
         if (c % 3 == 0 && c / 3 < 3) req_address = b2b_addr[c / 3 + 1];
         if (c == 11) begin
            req_valid  = 1'b0;
            resp_ready = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b:idle", 64'(req_ready), 64'd1);

      // Reset during ACCESS drops the strobe and the response.
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = 8'h18;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstacc:valid_before", 64'(register_valid),     64'b0100);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstacc:valid_drop",   64'(register_valid),     64'd0);
      check("rstacc:rmask_drop",   64'(register_read_mask), 64'd0);
      check("rstacc:ready_async",  64'(req_ready),          64'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rstacc:no_resp", 64'(resp_valid), 64'd0);
         check("rstacc:ready",   64'(req_ready),  64'd1);
      end

      run_access("post_rst", 1'b0, 8'h18, 32'h0, 4'h0, 4'b0100,
                 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b00, REG2, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
